// File: rtl/host_rx_pkg.sv
// Shared constants, flag encodings, FSM states and word layout for the host receive write path.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package host_rx_pkg;

  localparam int WORD_BYTES = 16;
  localparam int MAX_WORDS  = 128;

  // Position flag carried in bits [133:132] of every packet-buffer word.
  localparam logic [1:0] FLAG_HEAD   = 2'b01;
  localparam logic [1:0] FLAG_MID    = 2'b00;
  localparam logic [1:0] FLAG_TAIL   = 2'b10;
  localparam logic [1:0] FLAG_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DISC  = 2'd2
  } rx_state_t;

  // 134-bit packet-buffer word: flag, invalid-byte count, data (first byte at [127:120]).
  typedef struct packed {
    logic [1:0]   flag;
    logic [3:0]   inv;
    logic [127:0] dat;
  } pkt_word_t;

endpackage

// File: rtl/host_rx_byte_packer.sv
// Packs a byte stream into 16-byte buffer words, left-justified, with invalid-byte count.
// Latency: word and write strobe are registered, one cycle after the completing byte.
// Backpressure: none; accepts one byte per cycle whenever push is high.
//
// Ports: clk/rst_n (sync active-low); push/first/last/din describe the incoming byte,
// flag is the position flag to stamp on a word emitted this cycle; at_fill tells the
// caller the next pushed (non-first) byte completes a word; word_done is high in the
// cycle a word completes; word_wr/word are the registered word outputs.
module host_rx_byte_packer
  import host_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       first,
  input  logic       last,
  input  logic [7:0] din,
  input  logic [1:0] flag,
  output logic       at_fill,
  output logic       word_done,
  output logic       word_wr,
  output pkt_word_t  word
);

  logic [119:0] sr_q;      // up to 15 bytes waiting, newest in the low byte
  logic [3:0]   cnt_q;     // bytes currently held
  logic [119:0] sr_base;
  logic [3:0]   cnt_base;
  logic [127:0] sr_full;
  logic [4:0]   n_held;
  logic [3:0]   inv_c;

  always_comb begin
    // A first byte starts from an empty register regardless of leftovers.
    sr_base   = first ? '0 : sr_q;
    cnt_base  = first ? 4'd0 : cnt_q;
    sr_full   = {sr_base, din};
    n_held    = {1'b0, cnt_base} + 5'd1;
    inv_c     = 4'(5'd16 - n_held);  // 16 held bytes wraps to 0
    at_fill   = (cnt_q == 4'(WORD_BYTES - 1));
    word_done = push && (last || (cnt_base == 4'(WORD_BYTES - 1)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      word_wr <= 1'b0;
      word    <= '0;
    end else begin
      word_wr <= word_done;
      if (push) begin
        if (word_done) begin
          sr_q      <= '0;
          cnt_q     <= '0;
          word.flag <= flag;
          word.inv  <= inv_c;
          // Shift the held bytes up so the oldest lands at [127:120].
          word.dat  <= sr_full << {inv_c, 3'b000};
        end else begin
          sr_q  <= sr_full[119:0];
          cnt_q <= n_held[3:0];
        end
      end
    end
  end

endmodule

// File: rtl/host_rx_pkt_write.sv
// Writes host receive packets into the packet buffer and issues a 13-bit descriptor per packet.
// Latency: word write 1 cycle after the completing byte; descriptor valid 1 cycle after the tail write.
// Backpressure: descriptor held until ready; packets starting while a descriptor is pending are dropped.
//
// Ports: i_clk/i_rst_n (sync active-low); byte stream iv_data/i_data_wr/i_data_last;
// bufid offer iv_pkt_bufid/i_pkt_bufid_valid popped by o_pkt_bufid_ack; buffer write
// ov_pkt_data/o_pkt_data_wr/ov_pkt_waddr; descriptor ov_pkt_descriptor/o_pkt_descriptor_wr/
// i_pkt_descriptor_ready; event pulses o_pkt_cnt_pulse/o_pkt_discard_pulse/o_pkt_trunc_pulse;
// ov_discard_cnt (live only with HOST_RX_DISCARD_CNT_EN defined); ov_state for debug.
module host_rx_pkt_write
  import host_rx_pkg::*;
#(
  parameter logic [3:0] INPORT = 4'd8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [7:0]   iv_data,
  input  logic         i_data_wr,
  input  logic         i_data_last,
  input  logic [8:0]   iv_pkt_bufid,
  input  logic         i_pkt_bufid_valid,
  output logic         o_pkt_bufid_ack,
  output logic [133:0] ov_pkt_data,
  output logic         o_pkt_data_wr,
  output logic [15:0]  ov_pkt_waddr,
  output logic [12:0]  ov_pkt_descriptor,
  output logic         o_pkt_descriptor_wr,
  input  logic         i_pkt_descriptor_ready,
  output logic         o_pkt_cnt_pulse,
  output logic         o_pkt_discard_pulse,
  output logic         o_pkt_trunc_pulse,
  output logic [15:0]  ov_discard_cnt,
  output logic [1:0]   ov_state
);

  rx_state_t   state_q, state_d;
  logic [8:0]  bufid_q, cur_bufid;
  logic [6:0]  widx_q, cur_widx;
  logic [15:0] waddr_q;
  logic [12:0] desc_q;
  logic        desc_set, desc_set_q, desc_wr_q;
  logic        accept, pend;
  logic        start, push, discard, trunc;
  logic        ack_q, cnt_pulse_q, disc_pulse_q, trunc_pulse_q;
  logic [1:0]  flag;
  logic        at_fill, word_done;
  pkt_word_t   word;

  always_comb begin
    accept   = desc_wr_q && i_pkt_descriptor_ready;
    // Pending covers the cycle between tail write and descriptor assertion; an
    // acceptance this cycle already counts as clear.
    pend     = (desc_set_q || desc_wr_q) && !accept;
    state_d  = state_q;
    start    = 1'b0;
    push     = 1'b0;
    discard  = 1'b0;
    trunc    = 1'b0;
    desc_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_data_wr) begin
          if (i_pkt_bufid_valid && !pend) begin
            start = 1'b1;
            push  = 1'b1;
            if (i_data_last) desc_set = 1'b1;
            else             state_d  = ST_WRITE;
          end else begin
            discard = 1'b1;
            if (!i_data_last) state_d = ST_DISC;
          end
        end
      end
      ST_WRITE: begin
        if (i_data_wr) begin
          push = 1'b1;
          if (i_data_last) begin
            desc_set = 1'b1;
            state_d  = ST_IDLE;
          end else if (at_fill && (widx_q == 7'(MAX_WORDS - 1))) begin
            // Buffer full without an end marker: close it here, drop the rest.
            trunc    = 1'b1;
            desc_set = 1'b1;
            state_d  = ST_DISC;
          end
        end
      end
      ST_DISC: begin
        if (i_data_wr && i_data_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_widx  = start ? 7'd0 : widx_q;
    cur_bufid = start ? iv_pkt_bufid : bufid_q;
    if (i_data_last)                        flag = (cur_widx == 7'd0) ? FLAG_SINGLE : FLAG_TAIL;
    else if (cur_widx == 7'(MAX_WORDS - 1)) flag = FLAG_TAIL;
    else                                    flag = (cur_widx == 7'd0) ? FLAG_HEAD : FLAG_MID;
  end

  host_rx_byte_packer u_packer (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .first     (start),
    .last      (i_data_last),
    .din       (iv_data),
    .flag      (flag),
    .at_fill   (at_fill),
    .word_done (word_done),
    .word_wr   (o_pkt_data_wr),
    .word      (word)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      bufid_q       <= '0;
      widx_q        <= '0;
      waddr_q       <= '0;
      desc_q        <= '0;
      desc_set_q    <= 1'b0;
      desc_wr_q     <= 1'b0;
      ack_q         <= 1'b0;
      cnt_pulse_q   <= 1'b0;
      disc_pulse_q  <= 1'b0;
      trunc_pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) bufid_q <= iv_pkt_bufid;
      if (word_done) begin
        widx_q  <= cur_widx + 7'd1;
        waddr_q <= {cur_bufid, cur_widx};
      end else if (start) begin
        widx_q  <= '0;
      end
      desc_set_q <= desc_set;
      if (desc_set_q)  desc_wr_q <= 1'b1;
      else if (accept) desc_wr_q <= 1'b0;
      // Only loaded while nothing is pending, so the held value stays stable.
      if (desc_set) desc_q <= {INPORT, cur_bufid};
      ack_q         <= start;
      cnt_pulse_q   <= accept;
      disc_pulse_q  <= discard;
      trunc_pulse_q <= trunc;
    end
  end

`ifdef HOST_RX_DISCARD_CNT_EN
  logic [15:0] disc_cnt_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      disc_cnt_q <= '0;
    end else if (disc_pulse_q && (disc_cnt_q != 16'hFFFF)) begin
      disc_cnt_q <= disc_cnt_q + 16'd1;
    end
  end
  assign ov_discard_cnt = disc_cnt_q;
`else
  assign ov_discard_cnt = '0;
`endif

  assign ov_pkt_data         = word;
  assign ov_pkt_waddr        = waddr_q;
  assign ov_pkt_descriptor   = desc_q;
  assign o_pkt_descriptor_wr = desc_wr_q;
  assign o_pkt_bufid_ack     = ack_q;
  assign o_pkt_cnt_pulse     = cnt_pulse_q;
  assign o_pkt_discard_pulse = disc_pulse_q;
  assign o_pkt_trunc_pulse   = trunc_pulse_q;
  assign ov_state            = state_q;

endmodule
